// File: rtl/mac_seq_pkg.sv
// ---------------------------------------------------------------------------
// mac_seq_pkg: shared state type, MAC geometry and lane packing.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mac_seq_pkg;

  localparam int MAC_LANES = 4;
  localparam int MAC_IN_W  = 8;
  localparam int MAC_OUT_W = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

  // Lane k occupies bits [k*MAC_IN_W +: MAC_IN_W] of the packed word.
  function automatic logic [MAC_LANES*MAC_IN_W-1:0] pack_lanes(
    input logic [MAC_IN_W-1:0] lanes [MAC_LANES]
  );
    logic [MAC_LANES*MAC_IN_W-1:0] w_word;
    w_word = '0;
    for (int k = 0; k < MAC_LANES; k++) begin
      w_word[k*MAC_IN_W +: MAC_IN_W] = lanes[k];
    end
    return w_word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_dot_product_sequencer_tag_pipe.sv
// ---------------------------------------------------------------------------
// mac_tag_pipe: {valid,last} shift register tracking beats inside the MAC.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_tag_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clock0,
  input  logic aclr0,
  input  logic tag_valid_in,
  input  logic tag_last_in,
  output logic tag_valid_out,
  output logic tag_last_out
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_last;

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      r_valid <= '0;
      r_last  <= '0;
    end else begin
      r_valid[0] <= tag_valid_in;
      r_last[0]  <= tag_valid_in & tag_last_in;
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_valid[i] <= r_valid[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  assign tag_valid_out = r_valid[DEPTH-1];
  assign tag_last_out  = r_last[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mac_dot_product_sequencer.sv
// ---------------------------------------------------------------------------
// mac_dot_product_sequencer: streams operand beats through a 4-lane MAC and
// accumulates one signed dot product per packet.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_dot_product_sequencer
  import mac_seq_pkg::*;
#(
  parameter int MAC_LAT = 3,
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                          clock0,
  input  logic                          aclr0,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAC_LANES*MAC_IN_W-1:0] in_a,
  input  logic [MAC_LANES*MAC_IN_W-1:0] in_b,
  input  logic                          in_last,
  output logic [MAC_LANES*MAC_IN_W-1:0] mac_dataa,
  output logic [MAC_LANES*MAC_IN_W-1:0] mac_datab,
  input  logic [MAC_OUT_W-1:0]          mac_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_acc,
  output logic [CNT_W-1:0]              out_beats
);

  localparam logic [CNT_W-1:0] C_BEATS_MAX = '1;

  seq_state_t                    r_state;
  seq_state_t                    w_state_nxt;
  logic                          w_accept;
  logic                          w_tag_valid;
  logic                          w_tag_last;
  logic                          r_first;
  logic                          r_last_seen;
  logic [ACC_W-1:0]              r_acc;
  logic [CNT_W-1:0]              r_beats;
  logic [ACC_W-1:0]              r_out_acc;
  logic [CNT_W-1:0]              r_out_beats;
  logic [MAC_LANES*MAC_IN_W-1:0] r_mac_a;
  logic [MAC_LANES*MAC_IN_W-1:0] r_mac_b;
  logic signed [MAC_OUT_W-1:0]   w_res_s;
  logic [ACC_W-1:0]              w_res_ext;

  assign w_res_s   = mac_result;
  assign w_res_ext = ACC_W'(w_res_s);
  assign w_accept  = in_valid & in_ready;

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE, RUN: begin
        // Ready is forced low while reset is held, independent of state.
        in_ready = ~aclr0;
        if (in_valid && !aclr0) begin
          w_state_nxt = in_last ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (r_last_seen) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  mac_tag_pipe #(
    .DEPTH(MAC_LAT + 1)
  ) u_tag_pipe (
    .clock0       (clock0),
    .aclr0        (aclr0),
    .tag_valid_in (w_accept),
    .tag_last_in  (in_last),
    .tag_valid_out(w_tag_valid),
    .tag_last_out (w_tag_last)
  );

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_first     <= 1'b1;
      r_last_seen <= 1'b0;
      r_acc       <= '0;
      r_beats     <= '0;
      r_out_acc   <= '0;
      r_out_beats <= '0;
    end else begin
      // Idle operands are zero so the MAC contributes nothing on bubbles.
      r_mac_a <= w_accept ? in_a : '0;
      r_mac_b <= w_accept ? in_b : '0;

      if (r_state == IDLE) begin
        r_first <= 1'b1;
      end else if (w_tag_valid) begin
        r_first <= 1'b0;
      end

      if (w_tag_valid) begin
        r_acc <= (r_first ? '0 : r_acc) + w_res_ext;
      end

      r_last_seen <= (r_state == DRAIN) & w_tag_valid & w_tag_last;

      if (w_accept) begin
        if (r_state == IDLE) begin
          r_beats <= CNT_W'(1);
        end else if (r_beats != C_BEATS_MAX) begin
          r_beats <= r_beats + 1'b1;
        end
      end

      if (r_state == DRAIN && r_last_seen) begin
        r_out_acc   <= r_acc;
        r_out_beats <= r_beats;
      end
    end
  end

  assign mac_dataa = r_mac_a;
  assign mac_datab = r_mac_b;
  assign out_acc   = r_out_acc;
  assign out_beats = r_out_beats;

endmodule

`default_nettype wire

// File: tb/tb_mac_dot_product_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_dot_product_sequencer: two sequencer instances (wide, and narrow
// accumulator/counter) driven by one stream against a packet-level model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mac_dot_product_sequencer;
  import mac_seq_pkg::*;

  localparam int MAC_LAT = 3;

  logic        clock0;
  logic        aclr0;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready0, in_ready1;
  logic [31:0] mac_a0, mac_b0, mac_a1, mac_b1;
  logic [17:0] mac_res0, mac_res1;
  logic        out_valid0, out_valid1;
  logic [31:0] out_acc0;
  logic [17:0] out_acc1;
  logic [15:0] out_beats0;
  logic [1:0]  out_beats1;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qa2[$];
  logic [31:0] qb2[$];

  logic [17:0] mpipe0 [MAC_LAT];
  logic [17:0] mpipe1 [MAC_LAT];

  mac_dot_product_sequencer #(.MAC_LAT(MAC_LAT), .ACC_W(32), .CNT_W(16)) dut (
    .clock0(clock0), .aclr0(aclr0), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_dataa(mac_a0), .mac_datab(mac_b0), .mac_result(mac_res0),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_acc(out_acc0), .out_beats(out_beats0)
  );

  mac_dot_product_sequencer #(.MAC_LAT(MAC_LAT), .ACC_W(18), .CNT_W(2)) dut_n (
    .clock0(clock0), .aclr0(aclr0), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_dataa(mac_a1), .mac_datab(mac_b1), .mac_result(mac_res1),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_acc(out_acc1), .out_beats(out_beats1)
  );

  initial clock0 = 1'b0;
  always #5 clock0 = ~clock0;

  function automatic int dot4(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    for (int k = 0; k < MAC_LANES; k++) begin
      s += int'($signed(a[k*8 +: 8])) * int'($signed(b[k*8 +: 8]));
    end
    return s;
  endfunction

  function automatic logic [31:0] lanes4(input int l0, input int l1, input int l2, input int l3);
    logic [7:0] t [MAC_LANES];
    t[0] = 8'(l0);
    t[1] = 8'(l1);
    t[2] = 8'(l2);
    t[3] = 8'(l3);
    return pack_lanes(t);
  endfunction

  // Behavioural MAC: result appears MAC_LAT cycles after operands are driven.
  always @(posedge clock0) begin
    mpipe0[0] <= 18'(dot4(mac_a0, mac_b0));
    mpipe1[0] <= 18'(dot4(mac_a1, mac_b1));
    for (int i = 1; i < MAC_LAT; i++) begin
      mpipe0[i] <= mpipe0[i-1];
      mpipe1[i] <= mpipe1[i-1];
    end
  end
  assign mac_res0 = mpipe0[MAC_LAT-1];
  assign mac_res1 = mpipe1[MAC_LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock0);
    #1;
  endtask

  task automatic rand_packet(input int n);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back($urandom);
      qb.push_back($urandom);
    end
  endtask

  // bub_mode: 0 none, 1 one bubble before each later beat, 2 random bubbles.
  task automatic run_packet(input logic [31:0] pa[$], input logic [31:0] pb[$],
                            input int bub_mode, input int hold, input bit preload,
                            input logic [31:0] na, input logic [31:0] nb);
    logic signed [63:0] sum;
    int n, guard, k, early, exp_sat;
    sum = '0;
    n = pa.size();
    for (int b = 0; b < n; b++) begin
      if (b > 0 && (bub_mode == 1 || (bub_mode == 2 && $urandom_range(0, 1) == 1))) begin
        in_valid = 1'b0;
        step();
      end
      in_a = pa[b];
      in_b = pb[b];
      in_last = (b == n - 1);
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready0 && guard < 50) begin
        step();
        guard++;
      end
      check_eq("ready_wait", 64'(guard < 50), 1);
      step();
      sum += 64'(signed'(dot4(pa[b], pb[b])));
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_a = '0;
    in_b = '0;
    k = 0;
    early = 0;
    while (k < 20) begin
      step();
      k++;
      if (in_ready0) early++;
      if (out_valid0) break;
    end
    exp_sat = (n > 3) ? 3 : n;
    check_eq("latency", 64'(k), 64'(MAC_LAT + 2));
    check_eq("drain_ready", 64'(early), 0);
    check_eq("valid_narrow", 64'(out_valid1), 1);
    check_eq("acc_wide", 64'(out_acc0), 64'(sum[31:0]));
    check_eq("acc_narrow", 64'(out_acc1), 64'(sum[17:0]));
    check_eq("beats_wide", 64'(out_beats0), 64'(n));
    check_eq("beats_narrow", 64'(out_beats1), 64'(exp_sat));
    out_ready = 1'b0;
    if (preload) begin
      in_a = na;
      in_b = nb;
      in_last = 1'b0;
      in_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      step();
      check_eq("hold_acc", 64'(out_acc0), 64'(sum[31:0]));
      check_eq("hold_ready", 64'(in_ready0), 0);
      check_eq("hold_valid", 64'(out_valid0), 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("release_valid", 64'(out_valid0), 0);
    check_eq("release_ready", 64'(in_ready0), 1);
  endtask

  initial begin
    int cnt;
    aclr0 = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock0);
    #1;
    check_eq("rst_ready", 64'(in_ready0), 0);
    check_eq("rst_valid", 64'(out_valid0), 0);
    check_eq("rst_acc", 64'(out_acc0), 0);
    check_eq("rst_beats", 64'(out_beats0), 0);
    check_eq("rst_maca", 64'(mac_a0), 0);
    #2 aclr0 = 1'b0;
    #1 check_eq("post_rst_ready", 64'(in_ready0), 1);
    step();

    // Single beat: 1*5+2*6+3*7+4*8 = 70.
    qa.delete(); qb.delete();
    qa.push_back(lanes4(1, 2, 3, 4));
    qb.push_back(lanes4(5, 6, 7, 8));
    run_packet(qa, qb, 0, 0, 1'b0, '0, '0);
    check_eq("single_70", 64'(dot4(qa[0], qb[0])), 70);

    // Signed extremes with bubbles between beats.
    qa.delete(); qb.delete();
    qa.push_back(lanes4(-128, -128, -1, 64));   qb.push_back(lanes4(127, 127, -128, -2));
    qa.push_back(lanes4(-128, 5, -7, 0));       qb.push_back(lanes4(127, -3, 9, 127));
    qa.push_back(lanes4(-128, -128, -128, -128)); qb.push_back(lanes4(127, -128, 127, 1));
    run_packet(qa, qb, 1, 0, 1'b0, '0, '0);

    // Long hold with out_ready low.
    rand_packet(2);
    run_packet(qa, qb, 0, 10, 1'b0, '0, '0);

    // Narrow accumulator wraps: 3 * 65536 mod 2^18 = -65536.
    qa.delete(); qb.delete();
    for (int i = 0; i < 3; i++) begin
      qa.push_back(lanes4(-128, -128, -128, -128));
      qb.push_back(lanes4(-128, -128, -128, -128));
    end
    run_packet(qa, qb, 0, 0, 1'b0, '0, '0);
    check_eq("wrap_value", 64'(out_acc1), 64'(18'h30000));

    // Narrow counter saturates at 3.
    rand_packet(5);
    run_packet(qa, qb, 2, 1, 1'b0, '0, '0);

    // Back-to-back: next packet presented while the previous one is held.
    rand_packet(3);
    qa2.delete(); qb2.delete();
    for (int i = 0; i < 4; i++) begin
      qa2.push_back($urandom);
      qb2.push_back($urandom);
    end
    run_packet(qa, qb, 0, 4, 1'b1, qa2[0], qb2[0]);
    run_packet(qa2, qb2, 0, 0, 1'b0, '0, '0);

    for (int p = 0; p < 8; p++) begin
      rand_packet(int'($urandom_range(1, 8)));
      run_packet(qa, qb, 2, int'($urandom_range(0, 3)), 1'b0, '0, '0);
    end

    // Reset in the middle of a packet.
    rand_packet(4);
    in_a = qa[0]; in_b = qb[0]; in_last = 1'b0; in_valid = 1'b1;
    step();
    in_a = qa[1]; in_b = qb[1];
    step();
    in_valid = 1'b0;
    #2 aclr0 = 1'b1;
    #1;
    check_eq("mid_rst_ready", 64'(in_ready0), 0);
    check_eq("mid_rst_valid", 64'(out_valid0), 0);
    check_eq("mid_rst_acc", 64'(out_acc0), 0);
    check_eq("mid_rst_beats", 64'(out_beats0), 0);
    check_eq("mid_rst_maca", 64'(mac_a0), 0);
    @(posedge clock0);
    #2 aclr0 = 1'b0;
    #1 check_eq("mid_rst_release_ready", 64'(in_ready0), 1);
    cnt = 0;
    for (int i = 0; i < MAC_LAT + 6; i++) begin
      step();
      if (out_valid0 || out_valid1) cnt++;
    end
    check_eq("aborted_no_valid", 64'(cnt), 0);
    rand_packet(3);
    run_packet(qa, qb, 1, 0, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
